mouse_position_tracker: RTL and testbench
=========================================

MOUSE_POSITION_TRACKER -- requirements
Module: mouse_position_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the X and Y position outputs.
REQ-002 SHALL have parameter LIMIT_X, default 160: X positions run 0..LIMIT_X-1.
REQ-003 SHALL have parameter LIMIT_Y, default 120: Y positions run 0..LIMIT_Y-1.
REQ-004 SHALL have parameter SHIFT, default 0: the movement delta is arithmetic-right-shifted by SHIFT (sensitivity divider).
REQ-005 SHALL have parameter WRAP, default 0: 0 = clamp at the edges, 1 = modulo wrap-around.
REQ-006 SHALL have parameter INVERT_Y, default 1: 1 = negate dy so that upward mouse motion decreases Y.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port PKT_VALID, input, 1 bit: one-cycle strobe that qualifies STATUS, DX and DY.
REQ-010 SHALL have port STATUS, input, 8 bits: PS/2 status byte -- [0] left, [1] right, [2] middle, [3] always-1, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
REQ-011 SHALL have port DX, input, 8 bits: X movement magnitude byte.
REQ-012 SHALL have port DY, input, 8 bits: Y movement magnitude byte.
REQ-013 SHALL have port RECENTRE, input, 1 bit: synchronous request to move the position to the centre.
REQ-014 SHALL have port POS_X, output, WIDTH bits: current X position.
REQ-015 SHALL have port POS_Y, output, WIDTH bits: current Y position.
REQ-016 SHALL have port BUTTONS, output, 3 bits: {middle, right, left}, registered.
REQ-017 SHALL have port CLICK, output, 3 bits: one-cycle 0->1 edge pulse per button.
REQ-018 SHALL have port POS_VALID, output, 1 bit: one-cycle pulse marking an update of POS_X, POS_Y and BUTTONS.
REQ-019 SHALL have port PKT_ERR, output, 1 bit: one-cycle pulse marking a dropped packet.

Function
REQ-020 SHALL form a 2-stage pipeline that accepts one packet per cycle with no back-pressure; outputs update, and POS_VALID/CLICK pulse, exactly 2 cycles after the CLK edge that samples PKT_VALID=1.
REQ-021 Stage 1 SHALL build signed 9-bit deltas {STATUS[4],DX} and {STATUS[5],DY}.
REQ-022 Stage 1 SHALL replace an overflowed delta (STATUS[6] or STATUS[7] set) with +255 if its sign bit is 0, or -256 if its sign bit is 1.
REQ-023 Stage 1 SHALL apply the SHIFT arithmetic shift, then negate dy when INVERT_Y=1, holding each delta as signed 10-bit.
REQ-024 Stage 2 SHALL compute new = pos + delta at signed width WIDTH+2, with no intermediate overflow.
REQ-025 With WRAP=0, stage 2 SHALL set the position to 0 when new<0, to LIMIT-1 when new>LIMIT-1, and to new otherwise.
REQ-026 With WRAP=1, stage 2 SHALL first clamp the delta to ±(LIMIT-1), then add LIMIT when new<0 or subtract LIMIT when new>=LIMIT.
REQ-027 SHALL drop any packet with STATUS[3]=0: no position or button change, no POS_VALID, and PKT_ERR pulses in the cycle POS_VALID would have pulsed.
REQ-028 SHALL set CLICK[i] high when stage-2 BUTTONS[i] goes 0->1, coincident with POS_VALID.
REQ-029 RECENTRE=1 SHALL set POS_X=LIMIT_X/2 and POS_Y=LIMIT_Y/2 on the next edge.
REQ-030 When RECENTRE coincides with a valid packet in stage 2, RECENTRE SHALL win for position; that packet still updates BUTTONS and still pulses POS_VALID.
REQ-031 For back-to-back packets, stage 2 SHALL always add to the position produced by the previous packet (no lost updates).
REQ-032 Elaboration SHALL fail unless LIMIT_X and LIMIT_Y are each >= 2 and <= 2^WIDTH.

Reset
REQ-033 While RESET=0, outputs SHALL be POS_X=LIMIT_X/2, POS_Y=LIMIT_Y/2, BUTTONS=0, CLICK=0, POS_VALID=0, PKT_ERR=0, with both pipeline valid flags cleared.
REQ-034 A packet in flight when RESET asserts SHALL be discarded and SHALL produce no pulse after release.
REQ-035 SHALL accept the first packet on the first edge after RESET deasserts.

Verification
REQ-036 Defaults, after reset: STATUS=0x08, DX=0x05, DY=0x03 -> 2 cycles later POS_X=85, POS_Y=57, POS_VALID one cycle.
REQ-037 Defaults: STATUS=0x19, DX=0x00 (dx=-256) -> POS_X=0, BUTTONS=001, CLICK=001; repeat the packet -> CLICK=000.
REQ-038 WRAP=1, POS_X=150: STATUS=0x08, DX=0x14 -> POS_X=10; X-overflow packet STATUS=0x48 -> delta clamped to +159 -> POS_X=9.
REQ-039 STATUS=0x00 packet -> PKT_ERR pulse, positions unchanged, no POS_VALID; then 3 consecutive valid packets with dx=+1 -> POS_X +3 across 3 consecutive POS_VALID pulses.
REQ-040 SHIFT=2, dx=+7 -> POS_X +1; RECENTRE coincident with a stage-2 packet -> position 80/60, buttons updated.
REQ-041 RESET low one cycle after PKT_VALID -> no POS_VALID after release; outputs at centre values.

Source files
------------

// File: rtl/mouse_position_tracker.sv
// mouse_position_tracker
// Turns decoded PS/2 mouse packets into a bounded cursor position plus
// registered button state, click edges and a per-packet update strobe.
//
// Pipeline, one packet per cycle:
//   capture : the CLK edge that samples PKT_VALID=1 latches the raw packet
//   stage 1 : sign/overflow handling, sensitivity shift, optional Y invert
//   stage 2 : position accumulate with clamp or wrap, buttons, pulses
// Outputs therefore change on the second edge after the sampling edge.
//
// Handshake: PKT_VALID is a push-only strobe with no ready/back-pressure.
// Every cycle with PKT_VALID=1 is a new packet and is always consumed.
// STATUS/DX/DY only need to be meaningful in that cycle.

module mouse_position_tracker #(
   parameter int WIDTH    = 8,
   parameter int LIMIT_X  = 160,
   parameter int LIMIT_Y  = 120,
   parameter int SHIFT    = 0,
   parameter int WRAP     = 0,
   parameter int INVERT_Y = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             PKT_VALID,
   input  logic [7:0]       STATUS,
   input  logic [7:0]       DX,
   input  logic [7:0]       DY,
   input  logic             RECENTRE,
   output logic [WIDTH-1:0] POS_X,
   output logic [WIDTH-1:0] POS_Y,
   output logic [2:0]       BUTTONS,
   output logic [2:0]       CLICK,
   output logic             POS_VALID,
   output logic             PKT_ERR
);

   // ------------------------------------------------------------------
   // Elaboration-time sanity: each axis needs at least two positions and
   // must be representable in WIDTH bits.
   // ------------------------------------------------------------------
   if ((LIMIT_X < 2) || (longint'(LIMIT_X) > (longint'(1) << WIDTH)) ||
       (LIMIT_Y < 2) || (longint'(LIMIT_Y) > (longint'(1) << WIDTH))) begin : g_bad_limits
      $error("mouse_position_tracker: LIMIT_X/LIMIT_Y must be in 2..2**WIDTH");
   end

   // Accumulator width. WIDTH+2 already holds pos + delta without overflow
   // for WIDTH >= 8; the floor of 11 keeps the full 10-bit delta exact when
   // a narrow WIDTH is chosen.
   localparam int SW = (WIDTH + 2 > 11) ? WIDTH + 2 : 11;

   localparam logic [WIDTH-1:0] CENTRE_X = WIDTH'(LIMIT_X / 2);
   localparam logic [WIDTH-1:0] CENTRE_Y = WIDTH'(LIMIT_Y / 2);

   // ------------------------------------------------------------------
   // Capture rank
   // ------------------------------------------------------------------
   logic       cap_valid;
   logic [7:0] cap_status;
   logic [7:0] cap_dx;
   logic [7:0] cap_dy;

   // Latch the raw packet on the edge that samples PKT_VALID.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cap_valid  <= 1'b0;
         cap_status <= 8'h00;
         cap_dx     <= 8'h00;
         cap_dy     <= 8'h00;
      end else begin
         cap_valid <= PKT_VALID;
         if (PKT_VALID) begin
            cap_status <= STATUS;
            cap_dx     <= DX;
            cap_dy     <= DY;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: delta formation
   // ------------------------------------------------------------------
   logic signed [8:0] raw_dx;
   logic signed [8:0] raw_dy;
   logic signed [9:0] shift_dx;
   logic signed [9:0] shift_dy;
   logic signed [9:0] delta_dx;
   logic signed [9:0] delta_dy;

   // Build signed 9-bit deltas, saturate on overflow, shift, then invert Y.
   always_comb begin
      raw_dx   = $signed({cap_status[4], cap_dx});
      raw_dy   = $signed({cap_status[5], cap_dy});
      shift_dx = '0;
      shift_dy = '0;
      delta_dx = '0;
      delta_dy = '0;

      // An overflowed axis reports the largest magnitude in its direction.
      if (cap_status[6]) begin
         raw_dx = cap_status[4] ? 9'sh100 : 9'sh0FF;
      end
      if (cap_status[7]) begin
         raw_dy = cap_status[5] ? 9'sh100 : 9'sh0FF;
      end

      // Arithmetic shift divides sensitivity (rounds toward -infinity).
      shift_dx = $signed({raw_dx[8], raw_dx}) >>> SHIFT;
      shift_dy = $signed({raw_dy[8], raw_dy}) >>> SHIFT;

      // 10 bits leave room for -(-256) = +256 after inversion.
      delta_dx = shift_dx;
      delta_dy = (INVERT_Y != 0) ? -shift_dy : shift_dy;
   end

   logic              s1_valid;
   logic              s1_ok;
   logic [2:0]        s1_btn;
   logic signed [9:0] s1_dx;
   logic signed [9:0] s1_dy;

   // Register the stage-1 result; STATUS[3] decides whether it is usable.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         s1_valid <= 1'b0;
         s1_ok    <= 1'b0;
         s1_btn   <= 3'b000;
         s1_dx    <= '0;
         s1_dy    <= '0;
      end else begin
         s1_valid <= cap_valid;
         if (cap_valid) begin
            s1_ok  <= cap_status[3];
            s1_btn <= cap_status[2:0];
            s1_dx  <= delta_dx;
            s1_dy  <= delta_dy;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: position update
   // ------------------------------------------------------------------

   // New coordinate for one axis. Clamp mode pins to the edges; wrap mode
   // first limits the step to less than one full lap so that a single
   // add/subtract of the limit brings it back into range.
   function automatic logic [WIDTH-1:0] step_pos(input logic [WIDTH-1:0] pos,
                                                 input logic signed [9:0] delta,
                                                 input int limit);
      logic signed [SW-1:0] p;
      logic signed [SW-1:0] d;
      logic signed [SW-1:0] lim;
      logic signed [SW-1:0] lim_m1;
      logic signed [SW-1:0] n;
      p      = $signed(SW'(pos));
      d      = SW'(delta);
      lim    = SW'(limit);
      lim_m1 = SW'(limit - 1);
      if (WRAP != 0) begin
         if (d > lim_m1) begin
            d = lim_m1;
         end else if (d < -lim_m1) begin
            d = -lim_m1;
         end
         n = p + d;
         if (n < 0) begin
            n = n + lim;
         end else if (n > lim_m1) begin
            n = n - lim;
         end
      end else begin
         n = p + d;
         if (n < 0) begin
            n = '0;
         end else if (n > lim_m1) begin
            n = lim_m1;
         end
      end
      return n[WIDTH-1:0];
   endfunction

   logic             take;
   logic [WIDTH-1:0] next_x;
   logic [WIDTH-1:0] next_y;

   // A packet lands in stage 2 only when it was valid and well-formed.
   always_comb begin
      take   = s1_valid & s1_ok;
      next_x = step_pos(POS_X, s1_dx, LIMIT_X);
      next_y = step_pos(POS_Y, s1_dy, LIMIT_Y);
   end

   // Output registers: position (recentre wins), buttons, one-cycle pulses.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         POS_X     <= CENTRE_X;
         POS_Y     <= CENTRE_Y;
         BUTTONS   <= 3'b000;
         CLICK     <= 3'b000;
         POS_VALID <= 1'b0;
         PKT_ERR   <= 1'b0;
      end else begin
         POS_VALID <= take;
         PKT_ERR   <= s1_valid & ~s1_ok;
         CLICK     <= 3'b000;
         if (take) begin
            BUTTONS <= s1_btn;
            CLICK   <= s1_btn & ~BUTTONS;
         end
         // Back-to-back packets chain through POS_X/POS_Y themselves, so
         // each one builds on the result of the one before it.
         if (RECENTRE) begin
            POS_X <= CENTRE_X;
            POS_Y <= CENTRE_Y;
         end else if (take) begin
            POS_X <= next_x;
            POS_Y <= next_y;
         end
      end
   end

endmodule

// File: tb/tb_mouse_position_tracker.sv
// tb_mouse_position_tracker
// Three trackers share one stimulus stream: clamp (defaults), wrap, and a
// SHIFT=2 sensitivity divider. A reference model computes every output
// from the packet rules in plain integer arithmetic; a negedge process
// compares all outputs each cycle, and directed steps pin literal values.

module tb_mouse_position_tracker;

   // ------------------------------------------------------------------
   // Clock / reset and DUT wiring
   // ------------------------------------------------------------------
   logic       CLK;
   logic       RESET;
   logic       PKT_VALID;
   logic [7:0] STATUS;
   logic [7:0] DX;
   logic [7:0] DY;
   logic       RECENTRE;

   logic [7:0] pos_x     [3];
   logic [7:0] pos_y     [3];
   logic [2:0] buttons   [3];
   logic [2:0] click     [3];
   logic       pos_valid [3];
   logic       pkt_err   [3];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   mouse_position_tracker #(.WRAP(0)) dut_clamp (
      .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .STATUS(STATUS),
      .DX(DX), .DY(DY), .RECENTRE(RECENTRE),
      .POS_X(pos_x[0]), .POS_Y(pos_y[0]), .BUTTONS(buttons[0]),
      .CLICK(click[0]), .POS_VALID(pos_valid[0]), .PKT_ERR(pkt_err[0])
   );

   mouse_position_tracker #(.WRAP(1)) dut_wrap (
      .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .STATUS(STATUS),
      .DX(DX), .DY(DY), .RECENTRE(RECENTRE),
      .POS_X(pos_x[1]), .POS_Y(pos_y[1]), .BUTTONS(buttons[1]),
      .CLICK(click[1]), .POS_VALID(pos_valid[1]), .PKT_ERR(pkt_err[1])
   );

   mouse_position_tracker #(.SHIFT(2)) dut_shift (
      .CLK(CLK), .RESET(RESET), .PKT_VALID(PKT_VALID), .STATUS(STATUS),
      .DX(DX), .DY(DY), .RECENTRE(RECENTRE),
      .POS_X(pos_x[2]), .POS_Y(pos_y[2]), .BUTTONS(buttons[2]),
      .CLICK(click[2]), .POS_VALID(pos_valid[2]), .PKT_ERR(pkt_err[2])
   );

   // ------------------------------------------------------------------
   // Scoreboard bookkeeping
   // ------------------------------------------------------------------
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   function automatic int cfg_shift(input int i);
      return (i == 2) ? 2 : 0;
   endfunction

   function automatic bit cfg_wrap(input int i);
      return (i == 1);
   endfunction

   // Signed movement for one axis after overflow saturation and division.
   function automatic int delta_of(input bit sign, input bit ovf, input logic [7:0] mag, input int shift);
      int d;
      if (ovf) d = sign ? -256 : 255;
      else     d = sign ? int'(mag) - 256 : int'(mag);
      return d >>> shift;
   endfunction

   function automatic int move(input int pos, input int d, input int limit, input bit wrap);
      int n;
      if (wrap) begin
         if (d > limit - 1)    d = limit - 1;
         if (d < -(limit - 1)) d = -(limit - 1);
         n = pos + d;
         if (n < 0)           n = n + limit;
         else if (n >= limit) n = n - limit;
         return n;
      end
      n = pos + d;
      if (n < 0)         return 0;
      if (n > limit - 1) return limit - 1;
      return n;
   endfunction

   typedef struct packed {
      logic       v;
      logic [7:0] st;
      logic [7:0] dx;
      logic [7:0] dy;
   } pkt_t;

   // Packets wait here until the edge at which their effect becomes visible.
   pkt_t exp_q[$];
   pkt_t cur_pkt;
   pkt_t head_pkt;

   int         m_x     [3] = '{80, 80, 80};
   int         m_y     [3] = '{60, 60, 60};
   logic [2:0] m_btn   [3] = '{3'b0, 3'b0, 3'b0};
   logic [2:0] m_click [3] = '{3'b0, 3'b0, 3'b0};
   logic       m_val   [3] = '{1'b0, 1'b0, 1'b0};
   logic       m_err   [3] = '{1'b0, 1'b0, 1'b0};

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         exp_q.delete();
         for (int i = 0; i < 3; i++) begin
            m_x[i] = 80; m_y[i] = 60; m_btn[i] = 3'b0;
            m_click[i] = 3'b0; m_val[i] = 1'b0; m_err[i] = 1'b0;
         end
      end else begin
         cur_pkt = '{PKT_VALID, STATUS, DX, DY};
         exp_q.push_back(cur_pkt);
         head_pkt = '0;
         // Effect appears two edges after the sampling edge.
         if (exp_q.size() > 2) head_pkt = exp_q.pop_front();
         for (int i = 0; i < 3; i++) begin
            m_val[i] = 1'b0; m_err[i] = 1'b0; m_click[i] = 3'b0;
            if (head_pkt.v && head_pkt.st[3]) begin
               m_val[i]   = 1'b1;
               m_click[i] = head_pkt.st[2:0] & ~m_btn[i];
               m_btn[i]   = head_pkt.st[2:0];
               m_x[i] = move(m_x[i], delta_of(head_pkt.st[4], head_pkt.st[6], head_pkt.dx, cfg_shift(i)),
                             160, cfg_wrap(i));
               m_y[i] = move(m_y[i], -delta_of(head_pkt.st[5], head_pkt.st[7], head_pkt.dy, cfg_shift(i)),
                             120, cfg_wrap(i));
            end else if (head_pkt.v) begin
               m_err[i] = 1'b1;
            end
            if (RECENTRE) begin
               m_x[i] = 80; m_y[i] = 60;
            end
         end
      end
   end

   // Every-cycle comparison of all three DUTs against the model.
   always @(negedge CLK) begin
      for (int i = 0; i < 3; i++) begin
         check($sformatf("model pos_x[%0d]", i),     32'(pos_x[i]),     m_x[i]);
         check($sformatf("model pos_y[%0d]", i),     32'(pos_y[i]),     m_y[i]);
         check($sformatf("model buttons[%0d]", i),   32'(buttons[i]),   32'(m_btn[i]));
         check($sformatf("model click[%0d]", i),     32'(click[i]),     32'(m_click[i]));
         check($sformatf("model pos_valid[%0d]", i), 32'(pos_valid[i]), 32'(m_val[i]));
         check($sformatf("model pkt_err[%0d]", i),   32'(pkt_err[i]),   32'(m_err[i]));
      end
   end

   // ------------------------------------------------------------------
   // Driver tasks (called at a negedge, return at a negedge)
   // ------------------------------------------------------------------
   task automatic drive(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
      PKT_VALID = 1'b1;
      STATUS    = s;
      DX        = x;
      DY        = y;
      @(negedge CLK);
   endtask

   task automatic pause(input int n);
      PKT_VALID = 1'b0;
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse_reset();
      RESET = 1'b0;
      pause(2);
      RESET = 1'b1;
   endtask

   // ------------------------------------------------------------------
   // Directed sequence with hand-computed literals
   // ------------------------------------------------------------------
   initial begin
      RESET = 1'b0; PKT_VALID = 1'b0; RECENTRE = 1'b0;
      STATUS = 8'h00; DX = 8'h00; DY = 8'h00;
      repeat (2) @(negedge CLK);
      check("reset pos_x", 32'(pos_x[0]), 80);
      check("reset pos_y", 32'(pos_y[0]), 60);
      check("reset buttons", 32'(buttons[0]), 0);
      check("reset pos_valid", 32'(pos_valid[0]), 0);
      RESET = 1'b1;

      // First packet right after release: +5 / +3 (Y inverted).
      drive(8'h08, 8'h05, 8'h03);
      pause(2);
      check("basic pos_x", 32'(pos_x[0]), 85);
      check("basic pos_y", 32'(pos_y[0]), 57);
      check("basic pos_valid", 32'(pos_valid[0]), 1);
      check("shift pos_x 5>>2", 32'(pos_x[2]), 81);
      check("shift pos_y 3>>2", 32'(pos_y[2]), 60);
      pause(1);
      check("basic pulse ends", 32'(pos_valid[0]), 0);

      // dx = -256 with left button: clamp to 0, wrap to 86, shift 81-64.
      drive(8'h19, 8'h00, 8'h00);
      pause(2);
      check("neg clamp pos_x", 32'(pos_x[0]), 0);
      check("left buttons", 32'(buttons[0]), 1);
      check("left click", 32'(click[0]), 1);
      check("neg wrap pos_x", 32'(pos_x[1]), 86);
      check("neg shift pos_x", 32'(pos_x[2]), 17);
      drive(8'h19, 8'h00, 8'h00);
      pause(2);
      check("held click", 32'(click[0]), 0);
      check("held buttons", 32'(buttons[0]), 1);

      // Wrap: 80 -> 150 -> 10 -> (+255 clamped to +159) 9, back-to-back.
      pulse_reset();
      drive(8'h08, 8'h46, 8'h00);
      drive(8'h08, 8'h14, 8'h00);
      drive(8'h48, 8'h00, 8'h00);
      check("wrap to 150", 32'(pos_x[1]), 150);
      pause(1);
      check("wrap past edge", 32'(pos_x[1]), 10);
      pause(1);
      check("wrap overflow", 32'(pos_x[1]), 9);
      check("clamp high edge", 32'(pos_x[0]), 159);

      // Dropped packet, then three consecutive +1 packets.
      pulse_reset();
      drive(8'h00, 8'h05, 8'h05);
      pause(2);
      check("drop pkt_err", 32'(pkt_err[0]), 1);
      check("drop pos_valid", 32'(pos_valid[0]), 0);
      check("drop pos_x", 32'(pos_x[0]), 80);
      drive(8'h08, 8'h01, 8'h00);
      drive(8'h08, 8'h01, 8'h00);
      drive(8'h08, 8'h01, 8'h00);
      check("chain 1", 32'(pos_x[0]), 81);
      pause(1);
      check("chain 2", 32'(pos_x[0]), 82);
      check("chain 2 valid", 32'(pos_valid[0]), 1);
      pause(1);
      check("chain 3", 32'(pos_x[0]), 83);
      pause(1);
      check("chain done valid", 32'(pos_valid[0]), 0);

      // SHIFT=2: +7 -> +1.
      drive(8'h08, 8'h07, 8'h00);
      pause(2);
      check("shift 7>>2", 32'(pos_x[2]), 81);

      // Recentre coincident with a packet reaching stage 2.
      drive(8'h0B, 8'h10, 8'h10);
      pause(1);
      RECENTRE = 1'b1;
      @(negedge CLK);
      RECENTRE = 1'b0;
      check("recentre pos_x", 32'(pos_x[0]), 80);
      check("recentre pos_y", 32'(pos_y[0]), 60);
      check("recentre buttons", 32'(buttons[0]), 3);
      check("recentre click", 32'(click[0]), 3);
      check("recentre pos_valid", 32'(pos_valid[0]), 1);

      // Y overflow downward (-256 inverted to +256).
      drive(8'hA8, 8'h00, 8'h00);
      pause(2);
      check("y ovf clamp", 32'(pos_y[0]), 119);
      check("y ovf wrap", 32'(pos_y[1]), 59);

      // Reset while a packet is in flight.
      drive(8'h09, 8'h05, 8'h05);
      PKT_VALID = 1'b0;
      RESET = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      for (int k = 0; k < 4; k++) begin
         pause(1);
         check("flight pos_valid", 32'(pos_valid[0]), 0);
      end
      check("flight pos_x", 32'(pos_x[0]), 80);
      check("flight pos_y", 32'(pos_y[0]), 60);
      check("flight buttons", 32'(buttons[0]), 0);

      pause(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
